// File: rtl/fft_in_framer_pkg.sv
// fft_in_framer_pkg: shared widths, ldn limits, framing states and sign-bit helper.
package fft_in_framer_pkg;
  localparam int MAN_W = 16;
  localparam int EXP_W = 6;
  localparam int SH_W = $clog2(MAN_W);
  localparam int CNT_W = 11;
  localparam logic [3:0] LDN_MIN = 4'd2;
  localparam logic [3:0] LDN_MAX = 4'd11;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic [3:0] clamp_ldn(input logic [3:0] l);
    return l < LDN_MIN ? LDN_MIN : l > LDN_MAX ? LDN_MAX : l;
  endfunction
  // count of bits below the MSB that still equal the sign bit
  function automatic logic [SH_W-1:0] sign_bits(input logic [MAN_W-1:0] x);
    logic run;
    run = 1'b1;
    sign_bits = '0;
    for (int i = MAN_W - 2; i >= 0; i--) begin
      run = run & (x[i] == x[MAN_W-1]);
      sign_bits = sign_bits + SH_W'(run);
    end
  endfunction
endpackage

// File: rtl/fft_in_framer_if.sv
// fft_in_framer_if: raw sample stream in, normalised block-floating-point stream out.
interface fft_in_framer_if #(parameter int IN_WIDTH = 16);
  import fft_in_framer_pkg::*;
  logic din_val;
  logic din_sop;
  logic signed [IN_WIDTH-1:0] din_real;
  logic signed [IN_WIDTH-1:0] din_imag;
  logic [3:0] ldn_req;
  logic block_sync;
  logic stage_sync;
  logic data_val;
  logic signed [MAN_W-1:0] data_real;
  logic signed [MAN_W-1:0] data_imag;
  logic signed [EXP_W-1:0] data_exp;
  logic [3:0] ldn_rg;
  logic sync_err;
  modport master(
    output din_val, din_sop, din_real, din_imag, ldn_req,
    input block_sync, stage_sync, data_val, data_real, data_imag, data_exp, ldn_rg, sync_err
  );
  modport slave(
    input din_val, din_sop, din_real, din_imag, ldn_req,
    output block_sync, stage_sync, data_val, data_real, data_imag, data_exp, ldn_rg, sync_err
  );
endinterface

// File: rtl/fft_in_framer_lsd_norm.sv
// fft_lsd_norm: common leading-sign normalisation of one complex sample.
module fft_lsd_norm
  import fft_in_framer_pkg::*;
(
  input  logic signed [MAN_W-1:0] re,
  input  logic signed [MAN_W-1:0] im,
  output logic signed [MAN_W-1:0] re_n,
  output logic signed [MAN_W-1:0] im_n,
  output logic signed [EXP_W-1:0] ex
);
  logic [SH_W-1:0] sr, si, s;
  always_comb begin
    sr = sign_bits(re);
    si = sign_bits(im);
    s = sr < si ? sr : si;
    re_n = re <<< s;
    im_n = im <<< s;
    ex = (re == '0 && im == '0) ? '0 : -EXP_W'(s);
  end
endmodule

// File: rtl/fft_in_framer.sv
// fft_in_framer: frames a complex sample stream into 2^ldn blocks and normalises each sample.
module fft_in_framer
  import fft_in_framer_pkg::*;
(
  input logic clk_sys,
  input logic rst_sys,
  fft_in_framer_if.slave bus
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, idx;
  logic [3:0] ldn_lat, ldn_nx, ldn1;
  logic restart, acc, last, v1, f1, e1;
  logic signed [MAN_W-1:0] re1, im1, re_n, im_n;
  logic signed [EXP_W-1:0] ex_n;
  // a sop always restarts the block; in RUN it means the previous block was cut short
  always_comb begin
    restart = bus.din_val & bus.din_sop;
    acc = bus.din_val & (restart | state == RUN);
    ldn_nx = restart ? clamp_ldn(bus.ldn_req) : ldn_lat;
    idx = restart ? '0 : cnt;
    last = idx == CNT_W'((12'd1 << ldn_nx) - 12'd1);
    state_nx = acc ? (last ? IDLE : RUN) : state;
    cnt_nx = acc ? (last ? '0 : idx + CNT_W'(1)) : cnt;
  end
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state <= IDLE;
      cnt <= '0;
      ldn_lat <= LDN_MIN;
      v1 <= 1'b0;
      f1 <= 1'b0;
      e1 <= 1'b0;
      ldn1 <= LDN_MIN;
      re1 <= '0;
      im1 <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ldn_lat <= ldn_nx;
      v1 <= acc;
      f1 <= restart;
      e1 <= restart & (state == RUN);
      if (acc) begin
        re1 <= MAN_W'(bus.din_real);
        im1 <= MAN_W'(bus.din_imag);
        ldn1 <= ldn_nx;
      end
    end
  end
  fft_lsd_norm u_norm (.re(re1), .im(im1), .re_n(re_n), .im_n(im_n), .ex(ex_n));
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      bus.data_val <= 1'b0;
      bus.block_sync <= 1'b0;
      bus.stage_sync <= 1'b0;
      bus.sync_err <= 1'b0;
      bus.data_real <= '0;
      bus.data_imag <= '0;
      bus.data_exp <= '0;
      bus.ldn_rg <= LDN_MIN;
    end else begin
      bus.data_val <= v1;
      bus.block_sync <= f1;
      bus.stage_sync <= f1;
      bus.sync_err <= e1;
      if (v1) begin
        bus.data_real <= re_n;
        bus.data_imag <= im_n;
        bus.data_exp <= ex_n;
        bus.ldn_rg <= ldn1;
      end
    end
  end
endmodule

// File: tb/tb_fft_in_framer.sv
// tb_fft_in_framer: randomized and directed stimulus against a queue-based framing/normalising model.
module tb_fft_in_framer;
  import fft_in_framer_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fft_in_framer_if #(.IN_WIDTH(16)) bus();
  fft_in_framer dut (.clk_sys(clk), .rst_sys(rst), .bus(bus));
  typedef struct {
    bit val;
    bit first;
    bit err;
    int re;
    int im;
    int ex;
    int ldn;
  } out_t;
  out_t q[$];
  out_t obs[$];
  out_t hold = '{0, 0, 0, 0, 0, 0, 2};
  int n_vec = 0;
  int n_err = 0;
  bit in_blk = 0;
  int idx = 0;
  int lat = 2;
  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask
  function automatic int clampi(input int l);
    return l < 2 ? 2 : l > 11 ? 11 : l;
  endfunction
  function automatic bit fits(input longint v);
    return v >= -32768 && v <= 32767;
  endfunction
  // largest shift keeping both parts inside the 16-bit signed range
  function automatic void norm(input int re, input int im, output int mr, output int mi, output int ex);
    int s;
    s = 0;
    if (re == 0 && im == 0) begin
      mr = 0; mi = 0; ex = 0;
    end else begin
      while (s < 15 && fits(longint'(re) <<< (s + 1)) && fits(longint'(im) <<< (s + 1))) s++;
      mr = re * (1 << s);
      mi = im * (1 << s);
      ex = -s;
    end
  endfunction
  always @(posedge clk) begin
    out_t e;
    e = '{0, 0, 0, 0, 0, 0, 0};
    if (rst) begin
      q.delete();
      in_blk = 0;
      idx = 0;
    end else begin
      if (bus.din_val && (bus.din_sop || in_blk)) begin
        if (bus.din_sop) begin
          e.err = in_blk;
          in_blk = 1;
          idx = 0;
          lat = clampi(int'(bus.ldn_req));
        end
        e.val = 1;
        e.first = (idx == 0);
        e.ldn = lat;
        norm(int'(bus.din_real), int'(bus.din_imag), e.re, e.im, e.ex);
        idx++;
        if (idx == (1 << lat)) in_blk = 0;
      end
      q.push_back(e);
    end
  end
  always @(negedge clk) begin
    out_t e;
    if (rst) begin
      q.delete();
      hold = '{0, 0, 0, 0, 0, 0, 2};
      e = hold;
    end else begin
      e = (q.size() >= 2) ? q[q.size() - 2] : '{0, 0, 0, 0, 0, 0, 0};
      if (q.size() > 2) q.pop_front();
      if (e.val) hold = e;
      else e = '{0, 0, 0, hold.re, hold.im, hold.ex, hold.ldn};
    end
    chk("data_val", int'(bus.data_val), int'(e.val));
    chk("block_sync", int'(bus.block_sync), int'(e.first));
    chk("stage_sync", int'(bus.stage_sync), int'(e.first));
    chk("sync_err", int'(bus.sync_err), int'(e.err));
    chk("data_real", int'(bus.data_real), e.re);
    chk("data_imag", int'(bus.data_imag), e.im);
    chk("data_exp", int'(bus.data_exp), e.ex);
    chk("ldn_rg", int'(bus.ldn_rg), e.ldn);
    if (bus.data_val)
      obs.push_back('{1, bus.block_sync, bus.sync_err, int'(bus.data_real), int'(bus.data_imag),
                      int'(bus.data_exp), int'(bus.ldn_rg)});
  end
  task automatic cyc(input bit v, input bit s, input int re, input int im, input int ldn);
    @(posedge clk);
    #1;
    bus.din_val = v;
    bus.din_sop = s;
    bus.din_real = re[15:0];
    bus.din_imag = im[15:0];
    bus.ldn_req = ldn[3:0];
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask
  initial begin
    int cnt;
    bus.din_val = 0;
    bus.din_sop = 0;
    bus.din_real = '0;
    bus.din_imag = '0;
    bus.ldn_req = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    idle(2);
    // ldn=2 block of re=1: 0x4000 at exp -14, trailing non-sop dropped
    obs.delete();
    cyc(1, 1, 1, 0, 2);
    repeat (3) cyc(1, 0, 1, 0, 2);
    cyc(1, 0, 1, 0, 2);
    idle(4);
    chk("t1_count", obs.size(), 4);
    chk("t1_first0", int'(obs[0].first), 1);
    chk("t1_first1", int'(obs[1].first), 0);
    chk("t1_re0", obs[0].re, 16384);
    chk("t1_re3", obs[3].re, 16384);
    chk("t1_im0", obs[0].im, 0);
    chk("t1_exp0", obs[0].ex, -14);
    // extreme and zero samples
    obs.delete();
    cyc(1, 1, -32768, 100, 2);
    cyc(1, 0, 0, 0, 2);
    cyc(1, 0, -1, 0, 2);
    cyc(1, 0, 3, -4, 2);
    idle(4);
    chk("t2_re_max", obs[0].re, -32768);
    chk("t2_im_max", obs[0].im, 100);
    chk("t2_exp_max", obs[0].ex, 0);
    chk("t2_re_zero", obs[1].re, 0);
    chk("t2_exp_zero", obs[1].ex, 0);
    chk("t2_re_m1", obs[2].re, -32768);
    chk("t2_exp_m1", obs[2].ex, -15);
    chk("t2_re_3", obs[3].re, 24576);
    chk("t2_im_m4", obs[3].im, -32768);
    chk("t2_exp_3", obs[3].ex, -13);
    // early sop truncates, then full block, then back-to-back block
    obs.delete();
    cyc(1, 1, 10, 0, 3);
    for (int i = 1; i < 4; i++) cyc(1, 0, 10 + i, 0, 3);
    cyc(1, 1, 20, 0, 3);
    for (int i = 1; i < 8; i++) cyc(1, 0, 20 + i, 0, 3);
    cyc(1, 1, 30, 0, 2);
    for (int i = 1; i < 4; i++) cyc(1, 0, 30 + i, 0, 2);
    cyc(1, 0, 99, 0, 2);
    idle(4);
    chk("t3_count", obs.size(), 16);
    chk("t3_err4", int'(obs[4].err), 1);
    chk("t3_first4", int'(obs[4].first), 1);
    chk("t3_err3", int'(obs[3].err), 0);
    chk("t3_first11", int'(obs[11].first), 0);
    chk("t3_first12", int'(obs[12].first), 1);
    chk("t3_err12", int'(obs[12].err), 0);
    chk("t3_ldn4", obs[4].ldn, 3);
    // ldn changes mid-block are ignored; clamping both ways
    obs.delete();
    cyc(1, 1, 5, 5, 3);
    repeat (7) cyc(1, 0, 5, 5, 5);
    cyc(1, 1, 6, 6, 15);
    cyc(1, 1, 7, 7, 0);
    repeat (3) cyc(1, 0, 7, 7, 0);
    idle(4);
    chk("t4_ldn_mid", obs[7].ldn, 3);
    chk("t4_ldn_hi", obs[8].ldn, 11);
    chk("t4_ldn_lo", obs[9].ldn, 2);
    chk("t4_err_lo", int'(obs[9].err), 1);
    // N=16 with random gaps
    obs.delete();
    cyc(1, 1, 1, 2, 4);
    for (int i = 1; i < 16; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      cyc(1, 0, int'($urandom()), int'($urandom()), 4);
    end
    idle(4);
    cnt = 0;
    foreach (obs[i]) cnt += int'(obs[i].first);
    chk("t5_count", obs.size(), 16);
    chk("t5_syncs", cnt, 1);
    // reset mid-block clears outputs at once; stray samples dropped until sop
    cyc(1, 1, 7, 7, 3);
    cyc(1, 0, 7, 7, 3);
    cyc(1, 0, 7, 7, 3);
    @(posedge clk);
    #1;
    rst = 1;
    bus.din_val = 0;
    bus.din_sop = 0;
    #1;
    chk("t6_val_rst", int'(bus.data_val), 0);
    chk("t6_re_rst", int'(bus.data_real), 0);
    chk("t6_ldn_rst", int'(bus.ldn_rg), 2);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    obs.delete();
    repeat (3) cyc(1, 0, 9, 9, 3);
    cyc(1, 1, 9, 9, 3);
    idle(4);
    chk("t6_count", obs.size(), 1);
    chk("t6_first", int'(obs[0].first), 1);
    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      int re, im, ldn;
      re = $urandom_range(0, 1) ? int'($urandom()) : int'($urandom_range(0, 15)) - 8;
      im = $urandom_range(0, 1) ? int'($urandom()) : int'($urandom_range(0, 15)) - 8;
      ldn = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 15)) : int'($urandom_range(2, 4));
      if ($urandom_range(0, 999) == 0) begin
        @(posedge clk);
        #1 rst = 1;
        bus.din_val = 0;
        @(posedge clk);
        #1 rst = 0;
      end
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, re, im, ldn);
    end
    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
